// File: rtl/bus_arbiter_if.sv
// bus_arbiter_if
//   One master's request/response port on the shared SoC data bus.
//   Master drives: req, write, addr[29:0] (word address), wdata[31:0], sel[3:0].
//   Arbiter drives: gnt (request latched), ack (transaction complete),
//                   err (read timed out, valid with ack), rdata[31:0] (valid with ack).
//   Modports: master = bus master side, slave = arbiter side.
interface bus_arbiter_if;
    logic        req;
    logic        write;
    logic [29:0] addr;
    logic [31:0] wdata;
    logic [3:0]  sel;
    logic        gnt;
    logic        ack;
    logic        err;
    logic [31:0] rdata;

    modport master (
        output req, write, addr, wdata, sel,
        input  gnt, ack, err, rdata
    );

    modport slave (
        input  req, write, addr, wdata, sel,
        output gnt, ack, err, rdata
    );
endinterface

// File: rtl/bus_arbiter.sv
// bus_arbiter
//   Shares the single SoC data bus between two masters (m0 = CPU data port,
//   m1 = UART debug/boot loader). One transaction in flight at a time,
//   round-robin on simultaneous requests, registered slave-side strobes.
//
//   Optional feature macro: BUS_ARB_TIMEOUT_EN
//     defined   -> parameter TIMEOUT exists; an un-acked read is force-completed
//                  with err=1, rdata=0 TIMEOUT cycles after its issue strobe.
//     undefined -> no counter, err is always 0, a read waits for read_ack forever.
//
//   Ports
//     clk, rst         system clock, synchronous active-high reset
//     m0, m1           master ports (bus_arbiter_if.slave)
//     mem_en           1-cycle issue strobe to slave decode
//     mem_write        transaction direction, valid with mem_en
//     addr, sel        latched word address / byte lanes
//     data_out         latched write data
//     data_in          slave read data, valid with read_ack
//     read_ack         slave read completion pulse
module bus_arbiter
`ifdef BUS_ARB_TIMEOUT_EN
#(
    parameter int TIMEOUT = 256
)
`endif
(
    input  logic                clk,
    input  logic                rst,
    bus_arbiter_if.slave        m0,
    bus_arbiter_if.slave        m1,
    output logic                mem_en,
    output logic                mem_write,
    output logic [29:0]         addr,
    output logic [3:0]          sel,
    output logic [31:0]         data_out,
    input  logic [31:0]         data_in,
    input  logic                read_ack
);

    typedef enum logic [1:0] {
        IDLE,
        ISSUE,
        WAIT,
        RESP
    } state_t;

    state_t      state;
    logic        rr_ptr;
    logic        owner;
    logic        pick;
    logic        grant_now;
    logic        resp_fire;
    logic        resp_err;
    logic [31:0] resp_data;
    logic        ack0_q;
    logic        ack1_q;
    logic        err0_q;
    logic        err1_q;
    logic [31:0] rdata0_q;
    logic [31:0] rdata1_q;

`ifdef BUS_ARB_TIMEOUT_EN
    localparam int CNT_W = $clog2(TIMEOUT) + 1;

    logic [CNT_W-1:0] tmo_cnt;
    logic             tmo_hit;

    // The counter is 0 in the first WAIT cycle, so the value TIMEOUT-2 marks the
    // last WAIT cycle; the forced response then lands TIMEOUT cycles after ISSUE.
    assign tmo_hit = (tmo_cnt == CNT_W'(TIMEOUT - 2));
`endif

    // rr_ptr names the master that wins a tie (the one not granted last time).
    always_comb begin
        pick = 1'b0;
        if (m0.req && m1.req) begin
            pick = rr_ptr;
        end else begin
            pick = m1.req;
        end
    end

    // Grant is combinational in IDLE so the master sees it in its request cycle;
    // it is masked during reset so every output reads 0 while rst is high.
    assign grant_now = (state == IDLE) && !rst && (m0.req || m1.req);
    assign m0.gnt    = grant_now && !pick;
    assign m1.gnt    = grant_now && pick;

    assign m0.ack    = ack0_q;
    assign m1.ack    = ack1_q;
    assign m0.err    = err0_q;
    assign m1.err    = err1_q;
    assign m0.rdata  = rdata0_q;
    assign m1.rdata  = rdata1_q;

    // Decides whether the transaction completes at the coming edge. A read_ack in
    // ISSUE or WAIT always beats a simultaneous timeout; outside those states it is
    // ignored, which drops stray or late slave acks.
    always_comb begin
        resp_fire = 1'b0;
        resp_err  = 1'b0;
        resp_data = '0;
        case (state)
            ISSUE: begin
                if (mem_write) begin
                    resp_fire = 1'b1;
                end else if (read_ack) begin
                    resp_fire = 1'b1;
                    resp_data = data_in;
                end
            end
            WAIT: begin
                if (read_ack) begin
                    resp_fire = 1'b1;
                    resp_data = data_in;
                end
`ifdef BUS_ARB_TIMEOUT_EN
                else if (tmo_hit) begin
                    resp_fire = 1'b1;
                    resp_err  = 1'b1;
                end
`endif
            end
            default: begin
            end
        endcase
    end

    // Main FSM. Strobes and response fields default to 0 every cycle so that
    // mem_en and the ack/err/rdata outputs are single-cycle pulses; the latched
    // address, lanes and write data stay put until the next grant.
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            rr_ptr    <= 1'b0;
            owner     <= 1'b0;
            mem_en    <= 1'b0;
            mem_write <= 1'b0;
            addr      <= '0;
            sel       <= '0;
            data_out  <= '0;
            ack0_q    <= 1'b0;
            ack1_q    <= 1'b0;
            err0_q    <= 1'b0;
            err1_q    <= 1'b0;
            rdata0_q  <= '0;
            rdata1_q  <= '0;
`ifdef BUS_ARB_TIMEOUT_EN
            tmo_cnt   <= '0;
`endif
        end else begin
            mem_en   <= 1'b0;
            ack0_q   <= 1'b0;
            ack1_q   <= 1'b0;
            err0_q   <= 1'b0;
            err1_q   <= 1'b0;
            rdata0_q <= '0;
            rdata1_q <= '0;

            case (state)
                IDLE: begin
                    if (grant_now) begin
                        owner     <= pick;
                        rr_ptr    <= ~pick;
                        mem_en    <= 1'b1;
                        mem_write <= pick ? m1.write : m0.write;
                        addr      <= pick ? m1.addr  : m0.addr;
                        sel       <= pick ? m1.sel   : m0.sel;
                        data_out  <= pick ? m1.wdata : m0.wdata;
                        state     <= ISSUE;
                    end
                end
                ISSUE: begin
`ifdef BUS_ARB_TIMEOUT_EN
                    tmo_cnt <= '0;
`endif
                    state <= WAIT;
                end
                WAIT: begin
`ifdef BUS_ARB_TIMEOUT_EN
                    tmo_cnt <= tmo_cnt + 1'b1;
`endif
                end
                RESP: begin
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase

            // Completion overrides the ISSUE/WAIT next-state chosen above and
            // routes the response only to the master that owns the transaction.
            if (resp_fire) begin
                state    <= RESP;
                ack0_q   <= !owner;
                ack1_q   <= owner;
                err0_q   <= !owner && resp_err;
                err1_q   <= owner && resp_err;
                rdata0_q <= owner ? '0 : resp_data;
                rdata1_q <= owner ? resp_data : '0;
            end
        end
    end

endmodule
